multicycle_decoder: RTL and testbench
=====================================

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 SHALL have parameter ALU_CTL_W, default 3: width of alu_ctl; values above 3 zero-extend the encodings.
REQ-002 SHALL have parameter ENABLE_BL, default 1: when 1, BL is supported through the link state; when 0, BL executes as plain B.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port reset  in  1  synchronous active-high reset.
REQ-006 Port op  in  2  instr[27:26].
REQ-007 Port funct  in  6  instr[25:20]; bit5=I, bits4:1=cmd, bit0=S/L.
REQ-008 Port rd  in  4  instr[15:12].
REQ-009 Port ir_write / next_pc / branch / reg_w / mem_w / link  out  1 each  write strobes.
REQ-010 Port adr_src  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-011 Port alu_src_a / alu_src_b / result_src  out  2 each  datapath mux selects.
REQ-012 Port imm_src / flag_w / reg_src  out  2 each  decode selects.
REQ-013 Port alu_ctl  out  ALU_CTL_W  ALU operation.
REQ-014 Port pcs / no_write / shift / swap / inv / illegal  out  1 each  decode flags.
REQ-015 Port state  out  4  current FSM state, for debug.

Function
REQ-016 SHALL implement a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, LINK=10; encodings 11-15 SHALL return to FETCH on the next clock.
REQ-017 Transitions: FETCH->DECODE.
REQ-018 From DECODE: op=01->MEMADR; op=00 with I=0->EXECR; op=00 with I=1->EXECI; op=10->BRANCH; op=11->FETCH, with illegal=1 for that DECODE cycle only.
REQ-019 From MEMADR: funct[0]=1->MEMREAD, else->MEMWRITE.
REQ-020 Other transitions: MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECR/EXECI->ALUWB->FETCH.
REQ-021 From BRANCH: ->LINK when ENABLE_BL=1 and funct[4]=1, else->FETCH; LINK->FETCH.
REQ-022 Cycles per instruction: B=3, BL=4, DP=4, STR=4, LDR=5.
REQ-023 FETCH outputs: adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10, ir_write=1, next_pc=1.
REQ-024 DECODE outputs: alu_src_a=01, alu_src_b=10, result_src=10.
REQ-025 MEMADR: alu_src_a=00, alu_src_b=01, alu_ctl forced to ADD.
REQ-026 MEMREAD: adr_src=1, result_src=00.
REQ-027 MEMWB: result_src=01, reg_w=1.
REQ-028 MEMWRITE: adr_src=1, result_src=00, mem_w=1.
REQ-029 EXECR: alu_src_a=00, alu_src_b=00. EXECI: alu_src_a=00, alu_src_b=01.
REQ-030 ALUWB: result_src=00, reg_w=!no_write.
REQ-031 BRANCH: alu_src_a=10, alu_src_b=01, alu_ctl=ADD, result_src=10, branch=1.
REQ-032 LINK: alu_src_a=01, alu_src_b=10, alu_ctl=SUB, result_src=10, reg_w=1, link=1 (destination R14).
REQ-033 Any output not listed for a state SHALL be 0.
REQ-034 Combinational decode, valid in every state (Mealy on op/funct/rd), as follows.
REQ-035 imm_src: op=00->00, op=01->01, op=10->10, op=11->00.
REQ-036 reg_src: bit0=(op=10); bit1=(op=01 and funct[0]=0).
REQ-037 alu_ctl in EXECR/EXECI/ALUWB, by cmd: ADD 0100->000; SUB 0010 and CMP 1010->001; AND 0000->010; ORR 1100 and MOV 1101->011; ADC 0101->100; RSB 0011->001; MVN 1111->011; any other cmd->000.
REQ-038 alu_ctl in all other states: 000, except LINK=001.
REQ-039 Flags: shift=(cmd=1101); swap=(cmd=0011); inv=(cmd=1111); no_write=(cmd=1010).
REQ-040 flag_w[1]=S when op=00.
REQ-041 flag_w[0]=S when op=00 and the cmd is arithmetic (ADD, SUB, ADC, RSB, CMP).
REQ-042 flag_w SHALL be 00 when op!=00.
REQ-043 pcs SHALL be 1 when (rd=15 and op!=10 and a register-writing instruction) or op=10.
REQ-044 All outputs SHALL be qualified by state: they follow the registered state, not the next state.

Reset
REQ-045 On a rising clk edge with reset=1, state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-046 While reset=1, ir_write, next_pc, branch, reg_w, mem_w, link and illegal SHALL be forced to 0.
REQ-047 The first FETCH strobe SHALL occur in the first cycle after reset deasserts.

Verification
REQ-048 ADD R1: op=00, funct=001000, rd=1 -> state sequence 0,1,6,8,0; reg_w=1 in ALUWB only; alu_ctl=000; flag_w=00.
REQ-049 LDR: op=01, funct=000001 -> state sequence 0,1,2,3,4,0; reg_w=1 only in MEMWB; adr_src=1 in MEMREAD; imm_src=01.
REQ-050 STR: op=01, funct=000000 -> state sequence 0,1,2,5,0; mem_w=1 for exactly one cycle; reg_w never 1.
REQ-051 CMP: op=00, funct=010101 -> no_write=1 and flag_w=11; reg_w=0 in ALUWB.
REQ-052 BL: op=10, funct=010000 -> ENABLE_BL=1 gives state sequence 0,1,9,10,0 with link=1 in LINK; ENABLE_BL=0 gives 0,1,9,0.
REQ-053 Reset asserted during MEMREAD -> next state FETCH; no reg_w pulse occurs. op=11 -> illegal=1 in DECODE, then FETCH.

Source files
------------

// File: rtl/multicycle_decoder.sv
// Multicycle ARM-subset control unit.
// A Moore FSM sequences each instruction through its datapath steps.
// The decode fields (imm_src, reg_src, flags, pcs) are combinational on op/funct/rd.
module multicycle_decoder #(
  parameter int ALU_CTL_W = 3,
  parameter bit ENABLE_BL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           op,
  input  logic [5:0]           funct,
  input  logic [3:0]           rd,
  output logic                 ir_write,
  output logic                 next_pc,
  output logic                 branch,
  output logic                 reg_w,
  output logic                 mem_w,
  output logic                 link,
  output logic                 adr_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic [1:0]           flag_w,
  output logic [1:0]           reg_src,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 pcs,
  output logic                 no_write,
  output logic                 shift,
  output logic                 swap,
  output logic                 inv,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    LINK     = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_ADC = 3'b100;

  state_t     state_q, state_d;
  logic [3:0] cmd;
  logic       s_bit, i_bit;
  logic       arith, reg_writer;
  logic [2:0] dp_alu, alu3;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign i_bit = funct[5];
  assign state = state_q;

  // State register; reset wins from any state, even mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state: the instruction class picks the path out of DECODE.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = i_bit ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = s_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = (ENABLE_BL && funct[4]) ? LINK : FETCH;
      LINK:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Data-processing ALU op chosen by cmd; RSB reuses SUB with swapped operands.
  always_comb begin
    dp_alu = ALU_ADD;
    case (cmd)
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b1010: dp_alu = ALU_SUB;
      4'b0011: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b1101: dp_alu = ALU_ORR;
      4'b1111: dp_alu = ALU_ORR;
      4'b0101: dp_alu = ALU_ADC;
      default: dp_alu = ALU_ADD;
    endcase
  end

  // Instruction-field decode, independent of state.
  always_comb begin
    shift    = (cmd == 4'b1101);
    swap     = (cmd == 4'b0011);
    inv      = (cmd == 4'b1111);
    no_write = (cmd == 4'b1010);
    arith    = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0101) ||
               (cmd == 4'b0011) || (cmd == 4'b1010);
    imm_src  = (op == 2'b11) ? 2'b00 : op;
    reg_src  = {(op == 2'b01) && !s_bit, (op == 2'b10)};
    flag_w   = (op == 2'b00) ? {s_bit, s_bit && arith} : 2'b00;
    // LDR and non-compare data processing are the only register writers.
    reg_writer = ((op == 2'b00) && !no_write) || ((op == 2'b01) && s_bit);
    pcs        = (op == 2'b10) || ((rd == 4'd15) && reg_writer);
  end

  // Per-state datapath controls; strobes are masked while reset is held.
  always_comb begin
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    link       = 1'b0;
    illegal    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu3       = ALU_ADD;
    case (state_q)
      FETCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = 1'b1;
        next_pc    = 1'b1;
      end
      DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        illegal    = (op == 2'b11);
      end
      MEMADR:   alu_src_b = 2'b01;
      MEMREAD:  adr_src   = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECR: alu3 = dp_alu;
      EXECI: begin
        alu_src_b = 2'b01;
        alu3      = dp_alu;
      end
      ALUWB: begin
        reg_w = !no_write;
        alu3  = dp_alu;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        alu3       = ALU_SUB;
        reg_w      = 1'b1;
        link       = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_write = 1'b0;
      next_pc  = 1'b0;
      branch   = 1'b0;
      reg_w    = 1'b0;
      mem_w    = 1'b0;
      link     = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign alu_ctl = ALU_CTL_W'(alu3);

endmodule

// File: tb/tb_multicycle_decoder.sv
// Bench for multicycle_decoder: directed instruction table, reset corner
// sequences, and random instructions against a path-level reference model.
module tb_multicycle_decoder;

  typedef struct packed {
    logic       ir_write, next_pc, branch, reg_w, mem_w, link, illegal, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, flag_w, reg_src;
    logic [2:0] alu_ctl;
    logic       pcs, no_write, shift, swap, inv;
  } ctl_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         cpi;
    int         cpi0;
    logic [1:0] flag_w;
    logic [1:0] imm_src;
    logic       pcs;
  } vec_t;

  typedef int iq_t[$];

  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] op = '0;
  logic [5:0] funct = '0;
  logic [3:0] rd = '0;

  ctl_t a, b;
  logic [3:0] st, st0;
  logic [3:0] alu0;
  int chk = 0, err = 0;

  always #5 clk = ~clk;

  multicycle_decoder dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .ir_write(a.ir_write), .next_pc(a.next_pc), .branch(a.branch), .reg_w(a.reg_w),
    .mem_w(a.mem_w), .link(a.link), .adr_src(a.adr_src), .alu_src_a(a.alu_src_a),
    .alu_src_b(a.alu_src_b), .result_src(a.result_src), .imm_src(a.imm_src),
    .flag_w(a.flag_w), .reg_src(a.reg_src), .alu_ctl(a.alu_ctl), .pcs(a.pcs),
    .no_write(a.no_write), .shift(a.shift), .swap(a.swap), .inv(a.inv),
    .illegal(a.illegal), .state(st)
  );

  // Second copy: no BL support and a widened alu_ctl.
  multicycle_decoder #(.ALU_CTL_W(4), .ENABLE_BL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .ir_write(b.ir_write), .next_pc(b.next_pc), .branch(b.branch), .reg_w(b.reg_w),
    .mem_w(b.mem_w), .link(b.link), .adr_src(b.adr_src), .alu_src_a(b.alu_src_a),
    .alu_src_b(b.alu_src_b), .result_src(b.result_src), .imm_src(b.imm_src),
    .flag_w(b.flag_w), .reg_src(b.reg_src), .alu_ctl(alu0), .pcs(b.pcs),
    .no_write(b.no_write), .shift(b.shift), .swap(b.swap), .inv(b.inv),
    .illegal(b.illegal), .state(st0)
  );
  assign b.alu_ctl = alu0[2:0];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // States visited by one instruction, ending on the FETCH that starts the next.
  function automatic iq_t path(logic [1:0] o, logic [5:0] f, bit en);
    iq_t q;
    q = {0, 1};
    case (o)
      2'b00: begin q.push_back(f[5] ? 7 : 6); q.push_back(8); end
      2'b01: begin
        q.push_back(2);
        if (f[0]) begin q.push_back(3); q.push_back(4); end
        else q.push_back(5);
      end
      2'b10: begin q.push_back(9); if (en && f[4]) q.push_back(10); end
      default: ;
    endcase
    q.push_back(0);
    return q;
  endfunction

  // Expected outputs for a given state and instruction.
  function automatic ctl_t model(int s, logic [1:0] o, logic [5:0] f, logic [3:0] r, logic rst);
    ctl_t c;
    logic [3:0] cmd;
    logic [2:0] alu_tab [16];
    logic wr;
    c = '0;
    cmd = f[4:1];
    foreach (alu_tab[i]) alu_tab[i] = 3'd0;
    alu_tab[2] = 3'd1; alu_tab[10] = 3'd1; alu_tab[3] = 3'd1; alu_tab[0] = 3'd2;
    alu_tab[12] = 3'd3; alu_tab[13] = 3'd3; alu_tab[15] = 3'd3; alu_tab[5] = 3'd4;
    c.shift = (cmd == 13); c.swap = (cmd == 3); c.inv = (cmd == 15); c.no_write = (cmd == 10);
    c.imm_src = (o == 3) ? 2'd0 : o;
    c.reg_src = {o == 1 && !f[0], o == 2};
    if (o == 0) c.flag_w = {f[0], f[0] && (cmd inside {4'd4, 4'd2, 4'd5, 4'd3, 4'd10})};
    wr = (o == 0 && cmd != 10) || (o == 1 && f[0]);
    c.pcs = (o == 2) || (r == 15 && wr);
    case (s)
      0:  begin c.alu_src_a = 1; c.alu_src_b = 2; c.result_src = 2; c.ir_write = 1; c.next_pc = 1; end
      1:  begin c.alu_src_a = 1; c.alu_src_b = 2; c.result_src = 2; c.illegal = (o == 3); end
      2:  c.alu_src_b = 1;
      3:  c.adr_src = 1;
      4:  begin c.result_src = 1; c.reg_w = 1; end
      5:  begin c.adr_src = 1; c.mem_w = 1; end
      6:  c.alu_ctl = alu_tab[cmd];
      7:  begin c.alu_src_b = 1; c.alu_ctl = alu_tab[cmd]; end
      8:  begin c.reg_w = (cmd != 10); c.alu_ctl = alu_tab[cmd]; end
      9:  begin c.alu_src_a = 2; c.alu_src_b = 1; c.result_src = 2; c.branch = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2; c.result_src = 2; c.alu_ctl = 1; c.reg_w = 1; c.link = 1; end
      default: ;
    endcase
    if (rst) begin
      c.ir_write = 0; c.next_pc = 0; c.branch = 0; c.reg_w = 0;
      c.mem_w = 0; c.link = 0; c.illegal = 0;
    end
    return c;
  endfunction

  // Reset, run one instruction to completion, check every cycle on both DUTs.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           output int cpi, output int cpi0);
    iq_t s1, s0;
    s1 = path(o, f, 1'b1);
    s0 = path(o, f, 1'b0);
    op = o; funct = f; rd = r; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_state", 64'(st), 64'd0);
    check("rst_ctl", 64'(a), 64'(model(0, o, f, r, 1'b1)));
    reset = 1'b0;
    #1;
    cpi = 12; cpi0 = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < s1.size()) begin
        check("state", 64'(st), 64'(s1[c]));
        check("ctl", 64'(a), 64'(model(s1[c], o, f, r, 1'b0)));
      end
      if (c < s0.size()) begin
        check("state_nobl", 64'(st0), 64'(s0[c]));
        check("alu_ctl_w4", 64'(alu0), 64'({1'b0, model(s0[c], o, f, r, 1'b0).alu_ctl}));
      end
      if (c > 0 && st0 == 0 && cpi0 < 0) cpi0 = c;
      if (c > 0 && st == 0) begin cpi = c; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 10 && st != 4'(target); i++) begin @(posedge clk); #1; end
    check("reach_state", 64'(st), 64'(target));
  endtask

  vec_t tab [10];
  int cpi, cpi0;

  initial begin
    //          op     funct      rd  cpi cpi0 flag_w imm   pcs
    tab[0] = '{2'b00, 6'b001000, 4'd1,  4, 4, 2'b00, 2'b00, 1'b0}; // ADD R1
    tab[1] = '{2'b01, 6'b000001, 4'd2,  5, 5, 2'b00, 2'b01, 1'b0}; // LDR
    tab[2] = '{2'b01, 6'b000000, 4'd3,  4, 4, 2'b00, 2'b01, 1'b0}; // STR
    tab[3] = '{2'b00, 6'b010101, 4'd0,  4, 4, 2'b11, 2'b00, 1'b0}; // CMP
    tab[4] = '{2'b10, 6'b010000, 4'd0,  4, 3, 2'b00, 2'b10, 1'b1}; // BL
    tab[5] = '{2'b10, 6'b000000, 4'd0,  3, 3, 2'b00, 2'b10, 1'b1}; // B
    tab[6] = '{2'b11, 6'b000000, 4'd0,  2, 2, 2'b00, 2'b00, 1'b0}; // illegal
    tab[7] = '{2'b00, 6'b111010, 4'd15, 4, 4, 2'b00, 2'b00, 1'b1}; // MOV PC,#imm
    tab[8] = '{2'b01, 6'b000001, 4'd15, 5, 5, 2'b00, 2'b01, 1'b1}; // LDR PC
    tab[9] = '{2'b00, 6'b000001, 4'd4,  4, 4, 2'b10, 2'b00, 1'b0}; // ANDS: logical, S only

    for (int i = 0; i < 10; i++) begin
      run_instr(tab[i].op, tab[i].funct, tab[i].rd, cpi, cpi0);
      check("cpi", 64'(cpi), 64'(tab[i].cpi));
      check("cpi_nobl", 64'(cpi0), 64'(tab[i].cpi0));
      check("flag_w", 64'(a.flag_w), 64'(tab[i].flag_w));
      check("imm_src", 64'(a.imm_src), 64'(tab[i].imm_src));
      check("pcs", 64'(a.pcs), 64'(tab[i].pcs));
    end

    // Reset during MEMREAD: abort to FETCH, no write-back, fetch on release.
    op = 2'b01; funct = 6'b000001; rd = 4'd5; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; #1;
    step_to(3);
    reset = 1'b1; #1;
    check("memread_rst_state", 64'(st), 64'd3);
    check("memread_rst_regw", 64'(a.reg_w), 64'd0);
    @(posedge clk); #1;
    check("abort_state", 64'(st), 64'd0);
    check("abort_regw", 64'(a.reg_w), 64'd0);
    check("abort_irw_held", 64'(a.ir_write), 64'd0);
    @(posedge clk); #1;
    check("held_state", 64'(st), 64'd0);
    reset = 1'b0; #1;
    check("first_fetch_irw", 64'(a.ir_write), 64'd1);
    check("first_fetch_npc", 64'(a.next_pc), 64'd1);

    // Reset asserted in MEMWB must mask the reg_w strobe.
    step_to(4);
    check("memwb_regw", 64'(a.reg_w), 64'd1);
    reset = 1'b1; #1;
    check("memwb_rst_regw", 64'(a.reg_w), 64'd0);
    @(posedge clk); #1;
    check("memwb_rst_state", 64'(st), 64'd0);

    // Reset asserted in DECODE of an illegal op masks illegal.
    op = 2'b11; reset = 1'b0;
    @(posedge clk); #1;
    check("ill_decode", 64'(a.illegal), 64'd1);
    reset = 1'b1; #1;
    check("ill_masked", 64'(a.illegal), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Random instructions against the path model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] ro;
      logic [5:0] rf;
      logic [3:0] rr;
      ro = 2'($urandom_range(0, 3));
      rf = 6'($urandom);
      rr = 4'($urandom);
      run_instr(ro, rf, rr, cpi, cpi0);
      check("rand_cpi", 64'(cpi), 64'(path(ro, rf, 1'b1).size() - 1));
      check("rand_cpi_nobl", 64'(cpi0), 64'(path(ro, rf, 1'b0).size() - 1));
    end

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
